// File: rtl/imm_decode_ctrl_pkg.sv
// Shared definitions for the decode-stage immediate sequencer:
// imm_type codes, base opcodes and the slot FSM encoding.
// IMM_DECODE_SKID_EN adds the SKID state used by the optional skid buffer.
package imm_decode_ctrl_pkg;

  localparam logic [2:0] IMM_R   = 3'b000;
  localparam logic [2:0] IMM_I   = 3'b001;
  localparam logic [2:0] IMM_S   = 3'b010;
  localparam logic [2:0] IMM_B   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_J   = 3'b101;
  localparam logic [2:0] IMM_CSR = 3'b110;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

`ifdef IMM_DECODE_SKID_EN
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01
  } state_t;
`endif

endpackage

// File: rtl/imm_decode_ctrl_immgen.sv
// Immediate generator: builds the sign-extended 32-bit immediate from
// instruction bits [31:7] for the given imm_type. CSR yields the zero-extended
// 5-bit zimm from the rs1 field; R-type yields zero.
module imm_decode_ctrl_immgen
  import imm_decode_ctrl_pkg::*;
(
  input  logic [31:7] instr_bits,
  input  logic [2:0]  imm_type,
  output logic [31:0] imm
);

  // Field selection per immediate format
  always_comb begin
    imm = 32'h0;
    case (imm_type)
      IMM_I:   imm = {{20{instr_bits[31]}}, instr_bits[31:20]};
      IMM_S:   imm = {{20{instr_bits[31]}}, instr_bits[31:25], instr_bits[11:7]};
      IMM_B:   imm = {{19{instr_bits[31]}}, instr_bits[31], instr_bits[7],
                      instr_bits[30:25], instr_bits[11:8], 1'b0};
      IMM_U:   imm = {instr_bits[31:12], 12'h000};
      IMM_J:   imm = {{11{instr_bits[31]}}, instr_bits[31], instr_bits[19:12],
                      instr_bits[20], instr_bits[30:21], 1'b0};
      IMM_CSR: imm = {27'h0, instr_bits[19:15]};
      default: imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Decode-stage sequencer: classifies the fetched opcode, generates the
// immediate and registers the result into a single decode slot for execute.
// Build option IMM_DECODE_SKID_EN adds a one-entry skid buffer and makes
// if_ready_out registered; without it if_ready_out is combinational.
//
// state    | meaning
// EMPTY    | decode slot empty, ready to accept
// FULL     | decode slot holds a valid instruction
// SKID     | slot and skid entry both occupied (skid build only)
module imm_decode_ctrl
  import imm_decode_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            flush_in,
  input  logic            if_valid_in,
  output logic            if_ready_out,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            ex_valid_out,
  input  logic            ex_ready_in,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [2:0]      imm_type_out,
  output logic [31:0]     imm_out,
  output logic            illegal_out
);

  // Returns {illegal, imm_type}; SYSTEM splits on funct3[2] (immediate CSR forms)
  function automatic logic [3:0] classify(input logic [6:0] opcode, input logic funct3_msb);
    logic [3:0] res;
    res = {1'b0, IMM_R};
    case (opcode)
      OP_OP:                               res = {1'b0, IMM_R};
      OP_IMM, OP_LOAD, OP_JALR, OP_FENCE:  res = {1'b0, IMM_I};
      OP_STORE:                            res = {1'b0, IMM_S};
      OP_BRANCH:                           res = {1'b0, IMM_B};
      OP_LUI, OP_AUIPC:                    res = {1'b0, IMM_U};
      OP_JAL:                              res = {1'b0, IMM_J};
      OP_SYSTEM:                           res = {1'b0, funct3_msb ? IMM_CSR : IMM_I};
      default:                             res = {1'b1, IMM_R};
    endcase
    return res;
  endfunction

  state_t      state, state_nxt;
  logic [3:0]  dec_class;
  logic [2:0]  dec_type;
  logic        dec_illegal;
  logic [31:0] dec_imm;
  logic        accept;
  logic        load_slot;
  logic        load_skid;
  logic        promote_skid;

  assign dec_class   = classify(instr_in[6:0], instr_in[14]);
  assign dec_type    = dec_class[2:0];
  assign dec_illegal = dec_class[3];

  imm_decode_ctrl_immgen u_immgen (
    .instr_bits (instr_in[31:7]),
    .imm_type   (dec_type),
    .imm        (dec_imm)
  );

  assign ex_valid_out = (state != ST_EMPTY);
  assign accept       = if_valid_in & if_ready_out & ~flush_in;

`ifdef IMM_DECODE_SKID_EN
  assign if_ready_out = (state != ST_SKID);
  assign load_slot    = accept & ((state == ST_EMPTY) | ((state == ST_FULL) & ex_ready_in));
  assign load_skid    = accept & (state == ST_FULL) & ~ex_ready_in;
  assign promote_skid = (state == ST_SKID) & ex_ready_in & ~flush_in;
`else
  assign if_ready_out = (state == ST_EMPTY) | ex_ready_in;
  assign load_slot    = accept;
  assign load_skid    = 1'b0;
  assign promote_skid = 1'b0;
`endif

  // Next-state: flush overrides everything and empties the pipeline slot(s)
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL: begin
        if (ex_ready_in)
          state_nxt = accept ? ST_FULL : ST_EMPTY;
`ifdef IMM_DECODE_SKID_EN
        else if (accept)
          state_nxt = ST_SKID;
`endif
      end
`ifdef IMM_DECODE_SKID_EN
      ST_SKID: if (ex_ready_in) state_nxt = ST_FULL;
`endif
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush_in) state_nxt = ST_EMPTY;
  end

`ifdef IMM_DECODE_SKID_EN
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [2:0]      skid_type;
  logic [31:0]     skid_imm;
  logic            skid_illegal;

  // Skid entry parks an instruction accepted while execute is stalled
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      skid_instr   <= '0;
      skid_pc      <= '0;
      skid_type    <= IMM_R;
      skid_imm     <= '0;
      skid_illegal <= 1'b0;
    end else if (load_skid) begin
      skid_instr   <= instr_in;
      skid_pc      <= pc_in;
      skid_type    <= dec_type;
      skid_imm     <= dec_imm;
      skid_illegal <= dec_illegal;
    end
  end
`endif

  // State register and decode slot; slot loads from decode or from the skid entry
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= ST_EMPTY;
      instr_out    <= '0;
      pc_out       <= '0;
      imm_type_out <= IMM_R;
      imm_out      <= '0;
      illegal_out  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_slot) begin
        instr_out    <= instr_in;
        pc_out       <= pc_in;
        imm_type_out <= dec_type;
        imm_out      <= dec_imm;
        illegal_out  <= dec_illegal;
      end
`ifdef IMM_DECODE_SKID_EN
      else if (promote_skid) begin
        instr_out    <= skid_instr;
        pc_out       <= skid_pc;
        imm_type_out <= skid_type;
        imm_out      <= skid_imm;
        illegal_out  <= skid_illegal;
      end
`endif
      if (flush_in) illegal_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed testbench for imm_decode_ctrl with hand-computed expected values.
module tb_imm_decode_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic        if_valid_in;
  logic        if_ready_out;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        ex_valid_out;
  logic        ex_ready_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [2:0]  imm_type_out;
  logic [31:0] imm_out;
  logic        illegal_out;

  int n_checks = 0;
  int n_fails  = 0;

  imm_decode_ctrl #(.XLEN(32)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .flush_in     (flush_in),
    .if_valid_in  (if_valid_in),
    .if_ready_out (if_ready_out),
    .instr_in     (instr_in),
    .pc_in        (pc_in),
    .ex_valid_out (ex_valid_out),
    .ex_ready_in  (ex_ready_in),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .imm_type_out (imm_type_out),
    .imm_out      (imm_out),
    .illegal_out  (illegal_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if_valid_in = v;
    instr_in    = ins;
    pc_in       = pc;
  endtask

  task automatic check_slot(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pc, input logic [2:0] ty,
                            input logic [31:0] imm, input logic ill);
    check({tag, ".valid"},   {31'h0, ex_valid_out}, {31'h0, v});
    check({tag, ".instr"},   instr_out, ins);
    check({tag, ".pc"},      pc_out, pc);
    check({tag, ".type"},    {29'h0, imm_type_out}, {29'h0, ty});
    check({tag, ".imm"},     imm_out, imm);
    check({tag, ".illegal"}, {31'h0, illegal_out}, {31'h0, ill});
  endtask

  initial begin
    rst_in      = 1'b1;
    flush_in    = 1'b0;
    ex_ready_in = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    step();
    rst_in = 1'b0;
    check_slot("reset", 1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0);
    check("reset.if_ready", {31'h0, if_ready_out}, 32'h1);

    // addi x1,x0,-1
    drive(1'b1, 32'hFFF00093, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check_slot("addi", 1'b1, 32'hFFF00093, 32'h100, 3'b001, 32'hFFFFFFFF, 1'b0);
    step();
    check("addi.drain", {31'h0, ex_valid_out}, 32'h0);

    // sw then jal back to back, no bubbles
    drive(1'b1, 32'h00112623, 32'h200);
    step();
    check_slot("sw", 1'b1, 32'h00112623, 32'h200, 3'b010, 32'h0000000C, 1'b0);
    drive(1'b1, 32'hFFDFF06F, 32'h204);
    #1;
    check("sw.if_ready", {31'h0, if_ready_out}, 32'h1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check_slot("jal", 1'b1, 32'hFFDFF06F, 32'h204, 3'b101, 32'hFFFFFFFC, 1'b0);
    step();
    check("jal.drain", {31'h0, ex_valid_out}, 32'h0);

    // lui held under back-pressure while csrrwi waits behind it
    ex_ready_in = 1'b0;
    drive(1'b1, 32'h123450B7, 32'h300);
    step();
    drive(1'b1, 32'h3002D073, 32'h304);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_slot($sformatf("lui_hold%0d", i), 1'b1, 32'h123450B7, 32'h300, 3'b100, 32'h12345000, 1'b0);
`ifdef IMM_DECODE_SKID_EN
      check($sformatf("lui_hold%0d.if_ready", i), {31'h0, if_ready_out}, (i == 0) ? 32'h1 : 32'h0);
`else
      check($sformatf("lui_hold%0d.if_ready", i), {31'h0, if_ready_out}, 32'h0);
`endif
      step();
    end
    ex_ready_in = 1'b1;
`ifdef IMM_DECODE_SKID_EN
    drive(1'b0, 32'h0, 32'h0);
`endif
    step();
    drive(1'b0, 32'h0, 32'h0);
    check_slot("csrrwi", 1'b1, 32'h3002D073, 32'h304, 3'b110, 32'h00000005, 1'b0);
    step();
    check("csrrwi.drain", {31'h0, ex_valid_out}, 32'h0);

    // illegal opcode
    drive(1'b1, 32'h0000007F, 32'h400);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check_slot("illegal", 1'b1, 32'h0000007F, 32'h400, 3'b000, 32'h0, 1'b1);

    // flush with slot full and a new instruction offered
    ex_ready_in = 1'b0;
    flush_in    = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h500);
    step();
    flush_in = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush.valid",   {31'h0, ex_valid_out}, 32'h0);
    check("flush.illegal", {31'h0, illegal_out}, 32'h0);
    check("flush.instr",   instr_out, 32'h0000007F);
    check("flush.if_ready", {31'h0, if_ready_out}, 32'h1);
    step();
    check("flush.dropped", {31'h0, ex_valid_out}, 32'h0);

    // reset while full and stalled
    drive(1'b1, 32'h123450B7, 32'h600);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("prereset.valid", {31'h0, ex_valid_out}, 32'h1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check_slot("midreset", 1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0);
    check("midreset.if_ready", {31'h0, if_ready_out}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
